// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types, constants and helpers for the RAM load/store front end.
//   size_e   : request size encoding (2'b11 is illegal and has no member)
//   state_e  : access FSM states
//   MASK_*   : RAM write masks (1 = bit NOT written)
//   isBadReq : flags illegal sizes and misaligned addresses
//   storeMask / storeLoData : lane mask and data for the first store beat
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_ISSUE_HI,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [15:0] MASK_NONE    = 16'h0000;
  localparam logic [15:0] MASK_ALL     = 16'hFFFF;
  localparam logic [15:0] MASK_LO_BYTE = 16'hFF00;
  localparam logic [15:0] MASK_HI_BYTE = 16'h00FF;

  // Size 2'b11 is illegal; halves need addr[0]=0 and words need addr[1:0]=00.
  function automatic logic isBadReq(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte stores write only the addressed lane; wider stores write the whole entry.
  function automatic logic [15:0] storeMask(input logic [1:0] size, input logic addr0);
    logic [15:0] m;
    if (size == SZ_BYTE) m = addr0 ? MASK_HI_BYTE : MASK_LO_BYTE;
    else                 m = MASK_NONE;
    return m;
  endfunction

  // The store byte is replicated to both lanes so the mask alone picks the lane.
  function automatic logic [15:0] storeLoData(input logic [1:0] size, input logic [15:0] data);
    logic [15:0] d;
    if (size == SZ_BYTE) d = {data[7:0], data[7:0]};
    else                 d = data;
    return d;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_load_ext.sv
// ---------------------------------------------------------------------------
// load_ext
// Combinational lane select plus sign/zero extension of load data.
//   i_raw      : raw data, {hi entry, lo entry} for words, lo entry in [15:0]
//   i_size     : request size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_addrLsb  : byte address bit 0, picks the byte lane
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : 32-bit extended result (0 for an illegal size)
// ---------------------------------------------------------------------------
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_size,
  input  logic        i_addrLsb,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0] w_byte;
  logic       w_byteSign;
  logic       w_halfSign;

  assign w_byte     = i_addrLsb ? i_raw[15:8] : i_raw[7:0];
  assign w_byteSign = w_byte[7] & ~i_unsigned;
  assign w_halfSign = i_raw[15] & ~i_unsigned;

  always_comb begin
    o_data = 32'h0;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byteSign}}, w_byte};
      SZ_HALF: o_data = {{16{w_halfSign}}, i_raw[15:0]};
      SZ_WORD: o_data = i_raw;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl
// Load/store front end for the 256x16 block RAM. Sequences byte, half and
// word requests (9-bit byte address, little-endian) onto the single 16-bit
// RAM port and returns extended load data.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_*               : request channel (valid/ready handshake)
//   resp_*              : one-cycle response pulse with error flag and data
//   ram_raddr/re        : RAM read port (data returns one cycle later)
//   ram_waddr/we/mask/wdata : RAM write port, mask bit 1 = not written
//   ram_rdata           : RAM read data
// All outputs are registered; RAM pins are set one edge ahead, from the
// request captured at accept or from the registered request afterwards.
// ---------------------------------------------------------------------------
module ram_access_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [7:0]  ram_raddr,
  output logic        ram_re,
  output logic [7:0]  ram_waddr,
  output logic        ram_we,
  output logic [15:0] ram_mask,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  state_e      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [8:0]  r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_lo;

  logic        w_accept;
  logic [31:0] w_raw;
  logic [31:0] w_extData;

  assign w_accept = req_valid && req_ready;

  // In WAIT the RAM presents the last entry read; words pair it with the
  // low half captured during ISSUE_HI.
  assign w_raw = (r_size == SZ_WORD) ? {ram_rdata, r_lo} : {16'h0, ram_rdata};

  load_ext u_loadExt (
    .i_raw      (w_raw),
    .i_size     (r_size),
    .i_addrLsb  (r_addr[0]),
    .i_unsigned (r_unsigned),
    .o_data     (w_extData)
  );

  // Single FSM: RAM pins default to inactive every cycle and are raised
  // only for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 9'h0;
      r_wdata    <= 32'h0;
      r_lo       <= 16'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      ram_raddr  <= 8'h0;
      ram_re     <= 1'b0;
      ram_waddr  <= 8'h0;
      ram_we     <= 1'b0;
      ram_mask   <= MASK_ALL;
      ram_wdata  <= 16'h0;
    end else begin
      resp_valid <= 1'b0;
      ram_raddr  <= 8'h0;
      ram_re     <= 1'b0;
      ram_waddr  <= 8'h0;
      ram_we     <= 1'b0;
      ram_mask   <= MASK_ALL;
      ram_wdata  <= 16'h0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            req_ready  <= 1'b0;
            if (isBadReq(req_size, req_addr[1:0])) begin
              r_state    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              r_state <= ST_ISSUE_LO;
              if (req_we) begin
                ram_waddr <= req_addr[8:1];
                ram_we    <= 1'b1;
                ram_mask  <= storeMask(req_size, req_addr[0]);
                ram_wdata <= storeLoData(req_size, req_wdata[15:0]);
              end else begin
                ram_raddr <= req_addr[8:1];
                ram_re    <= 1'b1;
              end
            end
          end
        end

        ST_ISSUE_LO: begin
          if (r_size == SZ_WORD) begin
            r_state <= ST_ISSUE_HI;
            if (r_we) begin
              ram_waddr <= r_addr[8:1] + 8'd1;
              ram_we    <= 1'b1;
              ram_mask  <= MASK_NONE;
              ram_wdata <= r_wdata[31:16];
            end else begin
              ram_raddr <= r_addr[8:1] + 8'd1;
              ram_re    <= 1'b1;
            end
          end else if (r_we) begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_ISSUE_HI: begin
          if (r_we) begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
          end else begin
            r_state <= ST_WAIT;
            r_lo    <= ram_rdata;
          end
        end

        ST_WAIT: begin
          r_state    <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= w_extData;
        end

        ST_RESP: begin
          r_state    <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end

        default: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_access_ctrl
// Directed bench for ram_access_ctrl with a behavioural 256x16 masked RAM.
// ---------------------------------------------------------------------------
module tb_ram_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  ram_raddr;
  logic        ram_re;
  logic [7:0]  ram_waddr;
  logic        ram_we;
  logic [15:0] ram_mask;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int checkCount = 0;
  int errorCount = 0;

  // Per-cycle capture of the last request, index 1 = first cycle after accept
  logic [7:0]  cWaddr [1:10];
  logic [15:0] cWdata [1:10];
  logic [15:0] cMask  [1:10];
  logic [7:0]  cRaddr [1:10];
  int          lastLat;
  logic [31:0] lastRdata;
  logic        lastErr;
  logic        anyWe;
  logic        anyRe;

  logic [15:0] mem [0:255];

  ram_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_raddr    (ram_raddr),
    .ram_re       (ram_re),
    .ram_waddr    (ram_waddr),
    .ram_we       (ram_we),
    .ram_mask     (ram_mask),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural block RAM: masked write, registered read
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    ram_rdata = 16'h0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= (mem[ram_waddr] & ram_mask) | (ram_wdata & ~ram_mask);
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request at a negedge, then samples every negedge until the response
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [8:0] addr, input logic [31:0] wdata);
    bit done;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lastLat = 0; lastRdata = 32'h0; lastErr = 1'b0; anyWe = 1'b0; anyRe = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 10 && !done; c++) begin
      @(negedge clk);
      cWaddr[c] = ram_waddr;
      cWdata[c] = ram_wdata;
      cMask[c]  = ram_mask;
      cRaddr[c] = ram_raddr;
      if (ram_we) anyWe = 1'b1;
      if (ram_re) anyRe = 1'b1;
      if (resp_valid) begin
        lastLat   = c;
        lastRdata = resp_rdata;
        lastErr   = resp_err;
        done      = 1'b1;
      end
    end
    if (!done) checkOutput("resp_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  int acceptCycle [0:1];
  int acceptCount;
  int respCount;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 9'h0; req_wdata = 32'h0;
    #12;
    checkOutput("rst_req_ready",  {31'h0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("rst_resp_err",   {31'h0, resp_err}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_ram_ctrl",   {30'h0, ram_re, ram_we}, 32'd0);
    checkOutput("rst_ram_mask",   {16'h0, ram_mask}, 32'h0000FFFF);
    checkOutput("rst_ram_addr",   {16'h0, ram_raddr, ram_waddr}, 32'h0);
    checkOutput("rst_ram_wdata",  {16'h0, ram_wdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store 0x004 <- 0xDEADBEEF
    applyStimulus(1'b1, 2'b10, 1'b0, 9'h004, 32'hDEADBEEF);
    checkOutput("wst_lat",    lastLat, 32'd3);
    checkOutput("wst_c1",     {cWaddr[1], cWdata[1], 8'h0}, {8'h02, 16'hBEEF, 8'h0});
    checkOutput("wst_c1_mask",{16'h0, cMask[1]}, 32'h0);
    checkOutput("wst_c2",     {cWaddr[2], cWdata[2], 8'h0}, {8'h03, 16'hDEAD, 8'h0});
    checkOutput("wst_rdata",  lastRdata, 32'h0);

    applyStimulus(1'b0, 2'b10, 1'b0, 9'h004, 32'h0);
    checkOutput("wld_lat",   lastLat, 32'd4);
    checkOutput("wld_raddr", {16'h0, cRaddr[1], cRaddr[2]}, 32'h00000203);
    checkOutput("wld_rdata", lastRdata, 32'hDEADBEEF);

    // Byte store 0x80 to 0x005
    applyStimulus(1'b1, 2'b00, 1'b0, 9'h005, 32'h00000080);
    checkOutput("bst_lat",   lastLat, 32'd2);
    checkOutput("bst_mask",  {16'h0, cMask[1]}, 32'h000000FF);
    checkOutput("bst_wdata", {16'h0, cWdata[1]}, 32'h00008080);
    checkOutput("bst_waddr", {24'h0, cWaddr[1]}, 32'h02);

    applyStimulus(1'b0, 2'b00, 1'b0, 9'h005, 32'h0);
    checkOutput("bld_s_lat",   lastLat, 32'd3);
    checkOutput("bld_s_rdata", lastRdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 9'h005, 32'h0);
    checkOutput("bld_u_rdata", lastRdata, 32'h00000080);
    applyStimulus(1'b0, 2'b10, 1'b0, 9'h004, 32'h0);
    checkOutput("wld2_rdata",  lastRdata, 32'hDEAD80EF);

    applyStimulus(1'b0, 2'b01, 1'b0, 9'h006, 32'h0);
    checkOutput("hld_lat",   lastLat, 32'd3);
    checkOutput("hld_rdata", lastRdata, 32'hFFFFDEAD);

    // Illegal requests: misaligned word, misaligned half, size 11
    applyStimulus(1'b1, 2'b10, 1'b0, 9'h002, 32'h11112222);
    checkOutput("err_w_lat", lastLat, 32'd1);
    checkOutput("err_w_flags", {29'h0, lastErr, anyWe, anyRe}, 32'b100);
    checkOutput("err_w_rdata", lastRdata, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 9'h003, 32'h0);
    checkOutput("err_h_lat", lastLat, 32'd1);
    checkOutput("err_h_flags", {29'h0, lastErr, anyWe, anyRe}, 32'b100);
    checkOutput("err_h_rdata", lastRdata, 32'h0);
    applyStimulus(1'b0, 2'b11, 1'b0, 9'h000, 32'h0);
    checkOutput("err_s_lat", lastLat, 32'd1);
    checkOutput("err_s_flags", {29'h0, lastErr, anyWe, anyRe}, 32'b100);

    // Top-of-memory word: entries 0xFE/0xFF, entry 0 untouched
    applyStimulus(1'b1, 2'b10, 1'b0, 9'h1FC, 32'h12345678);
    checkOutput("top_st_waddr", {16'h0, cWaddr[1], cWaddr[2]}, 32'h0000FEFF);
    checkOutput("top_no_wrap",  {16'h0, mem[0]}, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0);
    checkOutput("top_ld_raddr", {16'h0, cRaddr[1], cRaddr[2]}, 32'h0000FEFF);
    checkOutput("top_ld_rdata", lastRdata, 32'h12345678);

    // Low-lane byte store, then half loads
    applyStimulus(1'b1, 2'b00, 1'b0, 9'h000, 32'hFFFFFFA5);
    checkOutput("bst0_mask",  {16'h0, cMask[1]}, 32'h0000FF00);
    checkOutput("bst0_wdata", {16'h0, cWdata[1]}, 32'h0000A5A5);
    applyStimulus(1'b0, 2'b01, 1'b1, 9'h000, 32'h0);
    checkOutput("hld0_u_rdata", lastRdata, 32'h000000A5);
    applyStimulus(1'b0, 2'b01, 1'b0, 9'h1FE, 32'h0);
    checkOutput("hld_top_rdata", lastRdata, 32'h00001234);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 9'h004;
    acceptCount = 0; respCount = 0;
    for (int c = 0; c < 12; c++) begin
      if (resp_valid) respCount++;
      if (req_ready && acceptCount < 2) begin
        acceptCycle[acceptCount] = c;
        acceptCount++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("b2b_accepts", acceptCount, 32'd2);
    checkOutput("b2b_interval", acceptCycle[1] - acceptCycle[0], 32'd5);
    checkOutput("b2b_resps", respCount, 32'd2);
    for (int c = 0; c < 6; c++) @(negedge clk);

    // Reset asserted while a word load is in ISSUE_HI
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 9'h004;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("mrst_ram_re", {31'h0, ram_re}, 32'd0);
    respCount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      if (resp_valid) respCount++;
    end
    checkOutput("mrst_no_resp", respCount, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 9'h004, 32'h0);
    checkOutput("mrst_ld_lat", lastLat, 32'd4);
    checkOutput("mrst_ld_rdata", lastRdata, 32'hDEAD80EF);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
